addr_gen_engine: RTL and testbench

Parametrised address generator for the memory checker's transaction path. It replaces the fixed single-pattern address source with a configurable engine supporting seven address patterns, a bounded [base, limit] window, programmable stride, a programmable beat count, a seedable LFSR and a valid/ready output handshake. The block sits between the CSR/test-control logic, which supplies configuration and `start_i`, and the memory transaction builder, which consumes one address per handshake.

---
 rtl/addr_gen_engine.sv | 190 +++++++++++++++++++
 tb/tb_addr_gen_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_engine.sv
// addr_gen_engine: configurable address source for the memory checker.
// Issues count_i addresses over a valid/ready handshake using one of seven
// patterns (fixed, LFSR, walking-0, walking-1, increment, decrement,
// masked stride), all confined to a [base, limit] window where applicable.
module addr_gen_engine #(
    parameter int ADDR_W = 27,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2:0]        mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] limit_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [ADDR_W-1:0] addr_mask_i,
    input  logic [31:0]       seed_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              addr_ready_i,
    output logic              addr_valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] M_FIX   = 3'd0;
    localparam logic [2:0] M_RND   = 3'd1;
    localparam logic [2:0] M_RUN0  = 3'd2;
    localparam logic [2:0] M_RUN1  = 3'd3;
    localparam logic [2:0] M_INC   = 3'd4;
    localparam logic [2:0] M_DEC   = 3'd5;
    localparam logic [2:0] M_SMASK = 3'd6;
    localparam logic [2:0] M_RSVD  = 3'd7;

    // Fibonacci LFSR, taps 32/22/2/1 in 1-based numbering.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Keep base bits outside the mask, take variable bits inside it.
    function automatic logic [ADDR_W-1:0] merge_mask(input logic [ADDR_W-1:0] base,
                                                     input logic [ADDR_W-1:0] mask,
                                                     input logic [ADDR_W-1:0] vbits);
        return (base & ~mask) | (vbits & mask);
    endfunction

    logic [1:0]        r_state;
    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_limit;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_mask;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_lfsr;
    logic [CNT_W-1:0]  r_rem;
    logic              r_err;

    logic              w_valid;
    logic              w_hs;
    logic              w_start;
    logic              w_cfg_bad;
    logic              w_last_hs;
    logic [31:0]       w_seed;
    logic [31:0]       w_next_lfsr;
    logic [ADDR_W-1:0] w_next_offset;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W:0]   w_diff;
    logic [ADDR_W-1:0] w_first_addr;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_valid       = (r_state == S_RUN);
    assign w_hs          = w_valid && addr_ready_i;
    assign w_start       = start_i && (r_state == S_IDLE);
    assign w_last_hs     = w_hs && (r_rem == CNT_W'(1));
    assign w_cfg_bad     = (mode_i == M_RSVD) || (count_i == '0) ||
                           (((mode_i == M_INC) || (mode_i == M_DEC)) &&
                            (base_addr_i > limit_addr_i));
    assign w_seed        = (seed_i == 32'd0) ? 32'hFFFF_FFFF : seed_i;
    assign w_next_lfsr   = lfsr_step(r_lfsr);
    assign w_next_offset = r_offset + r_stride;
    // One extra bit captures carry-out (INC) and borrow (DEC).
    assign w_sum         = {1'b0, r_addr} + {1'b0, r_stride};
    assign w_diff        = {1'b0, r_addr} - {1'b0, r_stride};

    // First address of a run, derived straight from the config inputs.
    always_comb begin
        w_first_addr = base_addr_i;
        case (mode_i)
            M_FIX:   w_first_addr = base_addr_i;
            M_RND:   w_first_addr = merge_mask(base_addr_i, addr_mask_i, w_seed[ADDR_W-1:0]);
            M_RUN0:  w_first_addr = {{(ADDR_W-1){1'b1}}, 1'b0};
            M_RUN1:  w_first_addr = {{(ADDR_W-1){1'b0}}, 1'b1};
            M_INC:   w_first_addr = base_addr_i;
            M_DEC:   w_first_addr = limit_addr_i;
            M_SMASK: w_first_addr = merge_mask(base_addr_i, addr_mask_i, '0);
            default: w_first_addr = base_addr_i;
        endcase
    end

    // Address following the current one, from the latched config.
    always_comb begin
        w_next_addr = r_addr;
        case (r_mode)
            M_FIX:   w_next_addr = r_base;
            M_RND:   w_next_addr = merge_mask(r_base, r_mask, w_next_lfsr[ADDR_W-1:0]);
            M_RUN0,
            M_RUN1:  w_next_addr = {r_addr[ADDR_W-2:0], r_addr[ADDR_W-1]};
            M_INC:   w_next_addr = (w_sum[ADDR_W] || (w_sum[ADDR_W-1:0] > r_limit))
                                   ? r_base : w_sum[ADDR_W-1:0];
            M_DEC:   w_next_addr = (w_diff[ADDR_W] || (w_diff[ADDR_W-1:0] < r_base))
                                   ? r_limit : w_diff[ADDR_W-1:0];
            M_SMASK: w_next_addr = merge_mask(r_base, r_mask, w_next_offset);
            default: w_next_addr = r_base;
        endcase
    end

    // Control FSM: run sequencing, beat counter and sticky config error.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_cfg_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_rem   <= count_i;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) r_rem <= r_rem - CNT_W'(1);
                    // Abort wins; a coincident handshake still counts above.
                    if (abort_i || w_last_hs) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pattern state: config snapshot at start, advance only on handshakes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mode   <= M_FIX;
            r_base   <= '0;
            r_limit  <= '0;
            r_stride <= '0;
            r_mask   <= '0;
            r_offset <= '0;
            r_addr   <= '0;
            r_lfsr   <= 32'hFFFF_FFFF;
        end else if (w_start && !w_cfg_bad) begin
            r_mode   <= mode_i;
            r_base   <= base_addr_i;
            r_limit  <= limit_addr_i;
            r_stride <= stride_i;
            r_mask   <= addr_mask_i;
            r_offset <= '0;
            r_addr   <= w_first_addr;
            r_lfsr   <= w_seed;
        end else if (w_hs) begin
            r_offset <= w_next_offset;
            r_addr   <= w_next_addr;
            r_lfsr   <= w_next_lfsr;
        end
    end

    assign addr_valid_o = w_valid;
    assign addr_o       = r_addr;
    assign last_o       = w_valid && (r_rem == CNT_W'(1));
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;

endmodule

// File: tb/tb_addr_gen_engine.sv
// Directed bench for addr_gen_engine at ADDR_W=8.
module tb_addr_gen_engine;

    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, ready;
    logic [2:0]    mode;
    logic [AW-1:0] base, limit, stride, mask;
    logic [31:0]   seed;
    logic [CW-1:0] count;
    logic          valid, last, busy, done, err;
    logic [AW-1:0] addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    addr_gen_engine #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .mode_i(mode), .base_addr_i(base), .limit_addr_i(limit),
        .stride_i(stride), .addr_mask_i(mask), .seed_i(seed), .count_i(count),
        .addr_ready_i(ready), .addr_valid_o(valid), .addr_o(addr),
        .last_o(last), .busy_o(busy), .done_o(done), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns 1 time unit after the accepting edge.
    task automatic do_start(input logic [2:0] m, input logic [AW-1:0] b, input logic [AW-1:0] l,
                            input logic [AW-1:0] s, input logic [AW-1:0] mk,
                            input logic [31:0] sd, input logic [CW-1:0] c);
        mode = m; base = b; limit = l; stride = s; mask = mk; seed = sd; count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
        mode = '0; base = '0; limit = '0; stride = '0; mask = '0; seed = '0; count = '0;
        tick(); tick();
        n_checks++;
        if ({valid, last, busy, done, err} !== 5'b00000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b exp 00000", {valid, last, busy, done, err});
        end
        n_checks++;
        if (addr !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_addr: got %h exp 00", addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_inc();
        logic [AW-1:0] exp [6];
        exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        ready = 1'b1;
        do_start(3'd4, 8'h10, 8'h13, 8'h01, 8'h00, 32'd0, 16'd6);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, exp[i], (i == 5)}) begin
                n_errors++;
                $display("FAIL inc_beat%0d: got v=%b a=%h l=%b exp v=1 a=%h l=%b",
                         i, valid, addr, last, exp[i], (i == 5));
            end
            tick();
        end
        n_checks++;
        if ({valid, done, busy} !== 3'b011) begin
            n_errors++;
            $display("FAIL inc_done: got v/d/b=%b exp 011", {valid, done, busy});
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL inc_idle: got b/d=%b exp 00", {busy, done});
        end
    endtask

    task automatic test_dec_wrap();
        logic [AW-1:0] exp [4];
        exp = '{8'h20, 8'h18, 8'h10, 8'h20};
        do_start(3'd5, 8'h10, 8'h20, 8'h08, 8'h00, 32'd0, 16'd4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, exp[i], (i == 3)}) begin
                n_errors++;
                $display("FAIL dec_beat%0d: got v=%b a=%h l=%b exp a=%h", i, valid, addr, last, exp[i]);
            end
            tick();
        end
        tick();
        do_start(3'd4, 8'hF0, 8'hFF, 8'h20, 8'h00, 32'd0, 16'd2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, 8'hF0, (i == 1)}) begin
                n_errors++;
                $display("FAIL incwrap_beat%0d: got v=%b a=%h l=%b exp a=f0", i, valid, addr, last);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_patterns();
        logic [AW-1:0] e1 [9];
        logic [AW-1:0] e0 [3];
        logic [AW-1:0] es [3];
        e1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        e0 = '{8'hFE, 8'hFD, 8'hFB};
        es = '{8'hA0, 8'hA3, 8'hA6};
        do_start(3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 16'd9);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, e1[i], (i == 8)}) begin
                n_errors++;
                $display("FAIL run1_beat%0d: got v=%b a=%h l=%b exp a=%h", i, valid, addr, last, e1[i]);
            end
            tick();
        end
        tick();
        do_start(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, e0[i], (i == 2)}) begin
                n_errors++;
                $display("FAIL run0_beat%0d: got v=%b a=%h l=%b exp a=%h", i, valid, addr, last, e0[i]);
            end
            tick();
        end
        tick();
        do_start(3'd6, 8'hA0, 8'h00, 8'h03, 8'h0F, 32'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, es[i], (i == 2)}) begin
                n_errors++;
                $display("FAIL smask_beat%0d: got v=%b a=%h l=%b exp a=%h", i, valid, addr, last, es[i]);
            end
            tick();
        end
        tick();
        do_start(3'd0, 8'h55, 8'h00, 8'h07, 8'h00, 32'd0, 16'd2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, 8'h55, (i == 1)}) begin
                n_errors++;
                $display("FAIL fix_beat%0d: got v=%b a=%h l=%b exp a=55", i, valid, addr, last);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_rnd_backpressure();
        ready = 1'b0;
        do_start(3'd1, 8'hA0, 8'h00, 8'h00, 8'h0F, 32'd0, 16'd2);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, 8'hAF, 1'b0}) begin
                n_errors++;
                $display("FAIL rnd_hold%0d: got v=%b a=%h l=%b exp v=1 a=af l=0", i, valid, addr, last);
            end
            tick();
        end
        ready = 1'b1;
        n_checks++;
        if ({valid, addr, last} !== {1'b1, 8'hAF, 1'b0}) begin
            n_errors++;
            $display("FAIL rnd_beat0: got v=%b a=%h l=%b exp a=af l=0", valid, addr, last);
        end
        tick();
        n_checks++;
        if ({valid, addr, last} !== {1'b1, 8'hAE, 1'b1}) begin
            n_errors++;
            $display("FAIL rnd_beat1: got v=%b a=%h l=%b exp a=ae l=1", valid, addr, last);
        end
        tick();
        n_checks++;
        if ({valid, done} !== 2'b01) begin
            n_errors++;
            $display("FAIL rnd_done: got v/d=%b exp 01", {valid, done});
        end
        tick();
    endtask

    task automatic test_errors();
        logic [2:0]    em [3];
        logic [AW-1:0] eb [3];
        logic [AW-1:0] el [3];
        logic [CW-1:0] ec [3];
        em = '{3'd7, 3'd0, 3'd4};
        eb = '{8'h00, 8'h00, 8'h20};
        el = '{8'hFF, 8'hFF, 8'h10};
        ec = '{16'd1, 16'd0, 16'd4};
        for (int i = 0; i < 3; i++) begin
            do_start(em[i], eb[i], el[i], 8'h01, 8'h00, 32'd0, ec[i]);
            n_checks++;
            if ({valid, done, err, busy} !== 4'b0111) begin
                n_errors++;
                $display("FAIL err%0d_t1: got v/d/e/b=%b exp 0111", i, {valid, done, err, busy});
            end
            tick();
            n_checks++;
            if ({valid, done, err, busy} !== 4'b0010) begin
                n_errors++;
                $display("FAIL err%0d_t2: got v/d/e/b=%b exp 0010", i, {valid, done, err, busy});
            end
        end
        do_start(3'd0, 8'h33, 8'h00, 8'h00, 8'h00, 32'd0, 16'd1);
        n_checks++;
        if ({valid, addr, last, err} !== {1'b1, 8'h33, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL err_clear: got v=%b a=%h l=%b e=%b exp v=1 a=33 l=1 e=0", valid, addr, last, err);
        end
        tick();
        n_checks++;
        if ({valid, done, err} !== 3'b010) begin
            n_errors++;
            $display("FAIL err_clear_done: got v/d/e=%b exp 010", {valid, done, err});
        end
        tick();
    endtask

    task automatic test_abort();
        do_start(3'd4, 8'h00, 8'hFF, 8'h01, 8'h00, 32'd0, 16'd10);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, 8'(i), 1'b0}) begin
                n_errors++;
                $display("FAIL abort_beat%0d: got v=%b a=%h l=%b exp a=%h l=0", i, valid, addr, last, 8'(i));
            end
            if (i == 2) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        n_checks++;
        if ({valid, done, err, last} !== 4'b0100) begin
            n_errors++;
            $display("FAIL abort_done: got v/d/e/l=%b exp 0100", {valid, done, err, last});
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL abort_idle: got b/d=%b exp 00", {busy, done});
        end
    endtask

    task automatic test_reset_midrun();
        do_start(3'd4, 8'h40, 8'h80, 8'h04, 8'h00, 32'd0, 16'd10);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, last, busy, done, err, addr} !== {5'b00000, 8'h00}) begin
            n_errors++;
            $display("FAIL midrun_reset: got v/l/b/d/e=%b a=%h exp 00000 a=00",
                     {valid, last, busy, done, err}, addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(3'd4, 8'h04, 8'h08, 8'h01, 8'h00, 32'd0, 16'd2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({valid, addr, last} !== {1'b1, 8'(4 + i), (i == 1)}) begin
                n_errors++;
                $display("FAIL post_reset_beat%0d: got v=%b a=%h l=%b exp a=%h", i, valid, addr, last, 8'(4 + i));
            end
            tick();
        end
        n_checks++;
        if ({valid, done} !== 2'b01) begin
            n_errors++;
            $display("FAIL post_reset_done: got v/d=%b exp 01", {valid, done});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_inc();
        test_dec_wrap();
        test_patterns();
        test_rnd_backpressure();
        test_errors();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
